// File: rtl/scope_capture.sv
// scope_capture: pre/post-trigger capture of an 8-bit sample stream into a ring buffer.
// After capture, the buffer is read out oldest-first over a valid/ready stream.
// A one-slot skid register hides the one-cycle latency of the registered RAM read.
module scope_capture #(
    parameter int pDepthBits = 10,
    parameter int pPreTrig   = 256
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [7:0] iADC_Data,
    input  logic       iData_Valid,
    input  logic       iArm,
    input  logic [7:0] iTrigLevel,
    input  logic       iTrigRising,
    input  logic       iForce,
    output logic [7:0] oRd_Data,
    output logic       oRd_Valid,
    input  logic       iRd_Ready,
    output logic       oBusy,
    output logic       oTriggered,
    output logic       oDone
);
    localparam int DEPTH = 2 ** pDepthBits;
    localparam int AW    = pDepthBits;
    localparam int CW    = pDepthBits + 1;

    // The PRE count and the POST count share one counter; these are its terminal values.
    localparam logic [AW-1:0] PRE_LAST  = AW'(pPreTrig - 1);
    localparam logic [AW-1:0] POST_LAST = AW'(DEPTH - pPreTrig - 2);
    localparam logic [AW-1:0] PRE_OFS   = AW'(pPreTrig);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_XFER = CW'(DEPTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT_TRIG, S_POST, S_READOUT} state_t;

    state_t         state_q;
    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  cnt_q;
    logic [AW-1:0]  ta_q;
    logic [AW-1:0]  rd_addr_q;
    logic [CW-1:0]  fetch_cnt_q;
    logic [CW-1:0]  xfer_cnt_q;
    logic [7:0]     prev_q;
    logic           prev_valid_q;
    logic           force_q;
    logic           rd_pend_q;
    logic [7:0]     ram_q;
    logic [7:0]     out_data_q;
    logic           out_valid_q;
    logic [7:0]     skid_data_q;
    logic           skid_valid_q;
    logic           busy_q;
    logic           trig_q;
    logic           done_q;

    logic           capturing;
    logic           wr_en;
    logic           level_hit;
    logic           trig_hit;
    logic           pop;
    logic [1:0]     occ;
    logic [1:0]     occ_after;
    logic           rd_en;

    assign capturing = (state_q == S_PRE) || (state_q == S_WAIT_TRIG) || (state_q == S_POST);
    assign wr_en     = capturing && iData_Valid;
    assign level_hit = iTrigRising ? ((prev_q < iTrigLevel) && (iADC_Data >= iTrigLevel))
                                   : ((prev_q > iTrigLevel) && (iADC_Data <= iTrigLevel));
    assign trig_hit  = (state_q == S_WAIT_TRIG) && iData_Valid &&
                       (force_q || iForce || (prev_valid_q && level_hit));

    // Readout pipeline occupancy: output slot, skid slot and the RAM read in flight.
    // A new read is issued only if it still fits once this cycle's transfer is removed.
    assign pop       = out_valid_q && iRd_Ready;
    assign occ       = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(rd_pend_q);
    assign occ_after = occ - 2'(pop);
    assign rd_en     = (state_q == S_READOUT) && (fetch_cnt_q != DEPTH_C) && (occ_after < 2'd2);

    assign oRd_Data   = out_data_q;
    assign oRd_Valid  = out_valid_q;
    assign oBusy      = busy_q;
    assign oTriggered = trig_q;
    assign oDone      = done_q;

    // Sample buffer: one write port, one registered read port, no reset.
    always_ff @(posedge iCLK) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= iADC_Data;
        end
        if (rd_en) begin
            ram_q <= mem[rd_addr_q];
        end
    end

    // Capture state machine, pointers, and the readout output/skid registers.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            ta_q         <= '0;
            rd_addr_q    <= '0;
            fetch_cnt_q  <= '0;
            xfer_cnt_q   <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            force_q      <= 1'b0;
            rd_pend_q    <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            trig_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (iArm) begin
                        state_q      <= S_PRE;
                        wr_ptr_q     <= '0;
                        cnt_q        <= '0;
                        prev_valid_q <= 1'b0;
                        force_q      <= 1'b0;
                        busy_q       <= 1'b1;
                    end
                end
                S_PRE: begin
                    if (iData_Valid) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == PRE_LAST) begin
                            state_q <= S_WAIT_TRIG;
                            cnt_q   <= '0;
                        end
                    end
                end
                S_WAIT_TRIG: begin
                    if (iForce) begin
                        force_q <= 1'b1;
                    end
                    if (trig_hit) begin
                        state_q <= S_POST;
                        ta_q    <= wr_ptr_q;
                        trig_q  <= 1'b1;
                        force_q <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                S_POST: begin
                    if (iData_Valid) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == POST_LAST) begin
                            state_q     <= S_READOUT;
                            rd_addr_q   <= ta_q - PRE_OFS;
                            fetch_cnt_q <= '0;
                            xfer_cnt_q  <= '0;
                        end
                    end
                end
                S_READOUT: begin
                    if (pop) begin
                        xfer_cnt_q <= xfer_cnt_q + 1'b1;
                        if (xfer_cnt_q == LAST_XFER) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            trig_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (wr_en) begin
                wr_ptr_q     <= wr_ptr_q + 1'b1;
                prev_q       <= iADC_Data;
                prev_valid_q <= 1'b1;
            end

            if (rd_en) begin
                rd_addr_q   <= rd_addr_q + 1'b1;
                fetch_cnt_q <= fetch_cnt_q + 1'b1;
            end
            rd_pend_q <= rd_en;

            // Output slot refills from the skid slot first so order is preserved.
            if (!out_valid_q || pop) begin
                if (skid_valid_q) begin
                    out_data_q   <= skid_data_q;
                    out_valid_q  <= 1'b1;
                    skid_data_q  <= ram_q;
                    skid_valid_q <= rd_pend_q;
                end else begin
                    out_data_q  <= ram_q;
                    out_valid_q <= rd_pend_q;
                end
            end else if (rd_pend_q) begin
                skid_data_q  <= ram_q;
                skid_valid_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_scope_capture.sv
// Testbench for scope_capture with DEPTH=16 and four pre-trigger samples.
// Expected readout windows come from a small trigger model and are queued
// before each capture; every accepted readout sample is popped and compared.
module tb_scope_capture;
    localparam int DB    = 4;
    localparam int PT    = 4;
    localparam int DEPTH = 16;

    localparam int M_UP    = 0;
    localparam int M_DOWN  = 1;
    localparam int M_CONST = 2;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic [7:0] iADC_Data = '0;
    logic       iData_Valid = 1'b0;
    logic       iArm = 1'b0;
    logic [7:0] iTrigLevel = 8'h80;
    logic       iTrigRising = 1'b1;
    logic       iForce = 1'b0;
    logic       iRd_Ready = 1'b0;
    logic [7:0] oRd_Data;
    logic       oRd_Valid;
    logic       oBusy;
    logic       oTriggered;
    logic       oDone;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    bit stop_feed = 1'b0;

    scope_capture #(.pDepthBits(DB), .pPreTrig(PT)) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iADC_Data   (iADC_Data),
        .iData_Valid (iData_Valid),
        .iArm        (iArm),
        .iTrigLevel  (iTrigLevel),
        .iTrigRising (iTrigRising),
        .iForce      (iForce),
        .oRd_Data    (oRd_Data),
        .oRd_Valid   (oRd_Valid),
        .iRd_Ready   (iRd_Ready),
        .oBusy       (oBusy),
        .oTriggered  (oTriggered),
        .oDone       (oDone)
    );

    always #5 iCLK = ~iCLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] gen(input int mode, input int k);
        logic [7:0] kb;
        kb = 8'(k);
        case (mode)
            M_UP:    return kb;
            M_DOWN:  return 8'hFF - kb;
            default: return 8'h10;
        endcase
    endfunction

    // Model: find the first trigger sample and queue the DEPTH-sample window around it.
    task automatic push_expected(input int mode, input logic [7:0] lvl, input bit rising, input bit forced);
        logic [7:0] p;
        logic [7:0] c;
        bit hit;
        if (forced) begin
            for (int j = 0; j < DEPTH; j++) exp_q.push_back(8'h10);
        end else begin
            for (int i = PT; i < 256; i++) begin
                p = gen(mode, i - 1);
                c = gen(mode, i);
                hit = rising ? (p < lvl && c >= lvl) : (p > lvl && c <= lvl);
                if (hit) begin
                    for (int j = i - PT; j < i - PT + DEPTH; j++) exp_q.push_back(gen(mode, j));
                    break;
                end
            end
        end
    endtask

    // Drives samples; gap < 0 means random 0..7 idle cycles between samples.
    task automatic feed(input int mode, input int gap, input int force_at, input bit arm_mid, input int max_samples);
        int g;
        bit armed_ro;
        armed_ro = 1'b0;
        for (int k = 0; k < max_samples && !stop_feed; k++) begin
            g = (gap < 0) ? int'($urandom_range(0, 7)) : gap;
            for (int c = 0; c <= g; c++) begin
                iData_Valid = (c == 0);
                iADC_Data   = gen(mode, k);
                iForce      = (c == 1) && (k == force_at);
                iArm        = arm_mid && (k == 20) && (c == 0);
                if (arm_mid && !armed_ro && oRd_Valid) begin
                    iArm     = 1'b1;
                    armed_ro = 1'b1;
                end
                @(negedge iCLK);
                if (stop_feed) break;
            end
        end
        iData_Valid = 1'b0;
        iForce      = 1'b0;
        iArm        = 1'b0;
    endtask

    // Consumes readout samples and compares each accepted one against the queue.
    task automatic collect(input bit rand_ready);
        int n;
        int done_cnt;
        int post;
        int cyc;
        bit stalled;
        bit rdy;
        logic [7:0] held;
        logic [7:0] e;
        n = 0; done_cnt = 0; post = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (cyc < 4000 && post < 3) begin
            @(negedge iCLK);
            cyc++;
            if (oDone) done_cnt++;
            if (stalled) begin
                check_val("stall_valid", oRd_Valid, 1);
                check_val("stall_data", oRd_Data, held);
            end
            if (n == DEPTH) begin
                check_val("valid_after_last", oRd_Valid, 0);
                post++;
            end
            rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            iRd_Ready = rdy;
            if (oRd_Valid && rdy && n < DEPTH) begin
                if (exp_q.size() == 0) begin
                    check_val("q_underflow", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check_val($sformatf("rd_data[%0d]", n), oRd_Data, e);
                end
                if (n == 0) check_val("triggered_in_readout", oTriggered, 1);
                $display("xfer %0d data=0x%02h", n, oRd_Data);
                n++;
            end
            stalled = oRd_Valid && !rdy;
            held = oRd_Data;
        end
        iRd_Ready = 1'b0;
        stop_feed = 1'b1;
        check_val("xfer_count", n, DEPTH);
        check_val("done_pulses", done_cnt, 1);
        check_val("busy_after_done", oBusy, 0);
        check_val("trig_after_done", oTriggered, 0);
        check_val("queue_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic arm_pulse();
        iArm = 1'b1;
        @(negedge iCLK);
        iArm = 1'b0;
        check_val("busy_after_arm", oBusy, 1);
    endtask

    task automatic run(input string name, input int mode, input logic [7:0] lvl, input bit rising,
                       input int gap, input int force_at, input bit arm_mid, input bit rand_ready);
        $display("run %s", name);
        iTrigLevel  = lvl;
        iTrigRising = rising;
        stop_feed   = 1'b0;
        push_expected(mode, lvl, rising, force_at >= 0);
        arm_pulse();
        fork
            feed(mode, gap, force_at, arm_mid, 256);
            collect(rand_ready);
        join
        @(negedge iCLK);
    endtask

    task automatic pulse_reset();
        iRST = 1'b1;
        @(negedge iCLK);
        iRST = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge iCLK);
        iRST = 1'b0;
        check_val("rst_busy", oBusy, 0);
        check_val("rst_valid", oRd_Valid, 0);
        check_val("rst_triggered", oTriggered, 0);
        check_val("rst_done", oDone, 0);

        run("rising", M_UP, 8'h80, 1'b1, 4, -1, 1'b0, 1'b0);
        run("falling", M_DOWN, 8'h40, 1'b0, 4, -1, 1'b0, 1'b0);

        // Force pulsed during PRE must not trigger on a flat signal.
        $display("run force_in_pre");
        iTrigLevel = 8'h80; iTrigRising = 1'b1; stop_feed = 1'b0;
        arm_pulse();
        feed(M_CONST, 4, 1, 1'b0, 40);
        check_val("pre_force_trig", oTriggered, 0);
        check_val("pre_force_busy", oBusy, 1);
        check_val("pre_force_valid", oRd_Valid, 0);
        pulse_reset();
        check_val("pre_force_rst_busy", oBusy, 0);

        run("force_in_wait", M_CONST, 8'h80, 1'b1, 4, 10, 1'b0, 1'b0);
        run("backpressure", M_UP, 8'h80, 1'b1, 4, -1, 1'b0, 1'b1);

        // Reset after three post-trigger samples, then a clean re-capture.
        $display("run reset_mid_post");
        iTrigLevel = 8'h80; iTrigRising = 1'b1; stop_feed = 1'b0;
        arm_pulse();
        feed(M_UP, 4, -1, 1'b0, 132);
        check_val("post_triggered", oTriggered, 1);
        check_val("post_busy", oBusy, 1);
        pulse_reset();
        check_val("mid_rst_busy", oBusy, 0);
        check_val("mid_rst_valid", oRd_Valid, 0);
        check_val("mid_rst_triggered", oTriggered, 0);
        run("rearm_rising", M_UP, 8'h80, 1'b1, 4, -1, 1'b0, 1'b0);

        run("arm_mid_gaps", M_UP, 8'h80, 1'b1, -1, -1, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/scope_capture.md
SCOPE_CAPTURE -- requirements
Module: scope_capture

Interface
REQ-001 Parameter pDepthBits, default 10: capture buffer depth DEPTH = 2**pDepthBits samples.
REQ-002 Parameter pPreTrig, default 256: samples kept before the trigger sample; legal range 1..DEPTH-2.
REQ-003 iCLK  in  1  system clock (100 MHz); the single clock of the block.
REQ-004 iRST  in  1  reset; synchronous, active-high.
REQ-005 iADC_Data  in  8  ADC sample; qualified by iData_Valid.
REQ-006 iData_Valid  in  1  one-cycle strobe; one new sample per high cycle.
REQ-007 iArm  in  1  pulse; starts a capture.
REQ-008 iTrigLevel  in  8  trigger threshold, unsigned.
REQ-009 iTrigRising  in  1  1 = rising-edge trigger, 0 = falling-edge trigger.
REQ-010 iForce  in  1  force trigger immediately.
REQ-011 oRd_Data  out  8  readout sample.
REQ-012 oRd_Valid  out  1  oRd_Data holds a valid sample.
REQ-013 iRd_Ready  in  1  consumer accepts the sample.
REQ-014 oBusy  out  1  high in every state except IDLE.
REQ-015 oTriggered  out  1  high from trigger until the next return to IDLE.
REQ-016 oDone  out  1  one-cycle pulse when the last readout sample is accepted.

Function
REQ-017 States: IDLE, PRE, WAIT_TRIG, POST, READOUT.
REQ-018 IDLE: on iArm=1, go to PRE; clear the write pointer, the pre-fill counter and the previous-sample-valid flag.
REQ-019 iArm in any state other than IDLE: ignored.
REQ-020 PRE, WAIT_TRIG, POST: each iData_Valid=1 cycle writes the sample at the write pointer; the pointer increments modulo DEPTH.
REQ-021 Cycles with iData_Valid=0: no write, no counter change, no trigger evaluation.
REQ-022 PRE: go to WAIT_TRIG once pPreTrig samples have been written; no trigger is evaluated in PRE; iForce is ignored in PRE.
REQ-023 WAIT_TRIG: the ring overwrites freely.
REQ-024 Rising trigger: previous sample < iTrigLevel and current sample >= iTrigLevel.
REQ-025 Falling trigger: previous sample > iTrigLevel and current sample <= iTrigLevel.
REQ-026 Trigger evaluation requires the previous-sample-valid flag to be set.
REQ-027 Trigger sample is the current sample; it is written, its address is latched as TA, oTriggered is set, and the state goes to POST.
REQ-028 iForce=1 in WAIT_TRIG: trigger on the next valid sample regardless of level (iForce is latched until that sample arrives).
REQ-029 POST: write DEPTH-pPreTrig-1 further samples, then go to READOUT.
REQ-030 READOUT: read address starts at (TA - pPreTrig) mod DEPTH and increments modulo DEPTH; exactly DEPTH samples, oldest first.
REQ-031 iData_Valid is ignored in READOUT.
REQ-032 Handshake: a transfer occurs when oRd_Valid=1 and iRd_Ready=1.
REQ-033 While oRd_Valid=1 and iRd_Ready=0, oRd_Data is held stable.
REQ-034 oRd_Valid never drops without a transfer, except on reset.
REQ-035 First oRd_Valid within 3 cycles of entering READOUT.
REQ-036 With iRd_Ready held at 1, one transfer per cycle after the first (RAM read latency is hidden by a prefetch/skid register).
REQ-037 The DEPTH-th transfer pulses oDone for 1 cycle and returns to IDLE; oTriggered clears at the same time.
REQ-038 Buffer is a single-port-write/single-port-read RAM of DEPTH x 8 (inferable as iCE40 EBR).

Reset
REQ-039 iRST=1 at a clock edge, from any state: state <= IDLE; oRd_Valid, oBusy, oTriggered and oDone <= 0; pointers and counters <= 0; latched iForce cleared.
REQ-040 Buffer contents are undefined after reset and are not cleared.
REQ-041 iRST overrides every other input in the same cycle.

Verification (pDepthBits=4, pPreTrig=4, DEPTH=16)
REQ-042 Rising trigger: ramp 0x00..0xFF, one sample every 5 cycles, iTrigLevel=0x80, iTrigRising=1, arm at sample 0x00 -> readout 0x7C..0x8B in order, one oDone pulse.
REQ-043 Falling trigger: ramp 0xFF down, iTrigLevel=0x40, iTrigRising=0 -> readout 0x44..0x35.
REQ-044 Force: constant 0x10, iForce pulsed in WAIT_TRIG -> 16 readout samples of 0x10; pulse iForce in PRE instead -> no trigger.
REQ-045 Backpressure: iRd_Ready random at 50% duty -> each of the 16 samples is transferred exactly once, and oRd_Data is stable while stalled.
REQ-046 Reset mid-POST (after 3 post samples) -> next cycle oBusy=0, oRd_Valid=0, oTriggered=0; a re-arm then captures correctly per REQ-042.
REQ-047 iArm pulsed during WAIT_TRIG and during READOUT -> no effect; iData_Valid gaps of 0..7 cycles -> same readout as REQ-042.
